d_sel_arb: RTL and testbench
============================

# d_sel_arb

Two-requester arbiter that generates the registered select for the downstream 2:1 data selector. It drives `sel` (1 = channel one, 0 = channel two) plus one-hot grants. The choice is made by a three-state FSM with a minimum-dwell counter and round-robin fairness. It sits directly upstream of the selector and owns all decisions about which input reaches `dout`.

## Interface
- `HOLD_CYCLES`, default 4: minimum number of cycles a grant is held once issued. Legal range is 1..255.
- `CNT_W`, default 8: width of the dwell counter. It must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req_one`  input  1  channel one requests the selector. Level-sensitive, synchronous to `clk`.
- `req_two`  input  1  channel two requests the selector. Level-sensitive, synchronous to `clk`.
- `sel`  output  1  registered select to the downstream selector's `din_sel`: 1 = channel one, 0 = channel two.
- `grant_one`  output  1  registered; high while channel one owns the selector.
- `grant_two`  output  1  registered; high while channel two owns the selector.
- `busy`  output  1  registered; `grant_one | grant_two`.

## Operation
- States: IDLE, G_ONE, G_TWO. All outputs are decoded from registered state, so there are no combinational paths from input to output.
- Reset values: state IDLE, `sel`=0, `grant_one`=0, `grant_two`=0, `busy`=0, dwell counter 0, last-served pointer = TWO (channel one wins the first tie).
- Dwell counter:
  - Cleared to 0 on entry to G_ONE or G_TWO.
  - Increments each cycle spent in a grant state, saturating at HOLD_CYCLES-1.
  - `hold_done` = (counter == HOLD_CYCLES-1).
- IDLE transitions:
  - Exactly one request: go to that channel's grant state.
  - Both requests: go to the channel NOT equal to the last-served pointer.
  - No request: stay in IDLE.
- G_x transitions (x = own channel, y = other):
  - Before `hold_done`: stay, regardless of either request.
  - At or after `hold_done`, if `req_y`=1: go directly to G_y with no IDLE bubble, clearing the counter.
  - Otherwise, if `req_x`=0: go to IDLE.
  - Otherwise: stay.
- Last-served pointer updates to x on every entry to G_x.
- `sel` is set to 1 on entry to G_ONE and 0 on entry to G_TWO. In IDLE it holds its last value, so the downstream selector output never glitches on release.
- `grant_one` and `grant_two` are never both high.
- Reset asserted mid-grant: all state returns to reset values asynchronously. The first grant after `rst_n` rises follows IDLE rules.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. A request sampled at edge k produces a grant visible after edge k.
- `sel` changes on the same edge as the grant it accompanies. The downstream combinational selector reflects the new channel in that same cycle.
- Minimum grant length: HOLD_CYCLES cycles. With HOLD_CYCLES=1, a switch is possible every cycle.
- Switch latency once a competing request is pending: the request is honored at the first edge where `hold_done`=1. Worst case is HOLD_CYCLES cycles after grant entry.
- Release: own request low with `hold_done`=1 gives IDLE and grant low after 1 edge.

## Configuration
- `D_SEL_ARB_RR_EN` defined: round-robin arbitration as described under Operation (tie from IDLE goes to the non-last-served channel; a competing request preempts after dwell).
- `D_SEL_ARB_RR_EN` undefined: fixed priority, channel one highest.
  - Ties from IDLE go to G_ONE.
  - G_TWO yields to `req_one` after dwell.
  - G_ONE yields to `req_two` only after dwell AND when `req_one`=0.
  - The last-served pointer is unused.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with both requests high -> `sel`=0, both grants 0, `busy`=0. Release -> `grant_one`=1 and `sel`=1 after the first edge.
- Single requester, HOLD_CYCLES=4: pulse `req_two` for 1 cycle -> `grant_two` high exactly 4 cycles, then IDLE with `sel` still 0.
- Contention, RR enabled, HOLD_CYCLES=4: both requests held high for 20 cycles -> grants alternate ONE, TWO, ONE… every 4 cycles, with no overlap and no IDLE cycle between grants.
- Contention, macro undefined: both requests held high -> `grant_one` stays high continuously. Drop `req_one` -> `grant_two` asserts on the next edge (dwell already met).
- Reset mid-grant: assert `rst_n`=0 two cycles into G_ONE -> outputs drop asynchronously without waiting for a clock edge. After release with only `req_two`=1 -> G_TWO on the next edge.
- HOLD_CYCLES=1, alternating single-cycle requests `req_one`/`req_two` -> `sel` toggles every cycle, tracking the requests with 1-cycle latency.

Source files
------------

// File: rtl/d_sel_arb_if.sv
// d_sel_arb_if: request/grant bundle between the requesters and the
// select arbiter. "master" is the requester side, "slave" the arbiter side.
interface d_sel_arb_if;
    logic req_one;
    logic req_two;
    logic sel;
    logic grant_one;
    logic grant_two;
    logic busy;

    modport master (
        output req_one, req_two,
        input  sel, grant_one, grant_two, busy
    );

    modport slave (
        input  req_one, req_two,
        output sel, grant_one, grant_two, busy
    );
endinterface

// File: rtl/d_sel_arb.sv
// d_sel_arb: two-requester arbiter producing the registered select and
// one-hot grants for the downstream 2:1 data selector.
// IDLE / G_ONE / G_TWO FSM with a minimum-dwell counter.
// Build option D_SEL_ARB_RR_EN: defined -> round-robin fairness,
// undefined -> fixed priority with channel one highest.
module d_sel_arb #(
    parameter int HOLD_CYCLES = 4,   // 1..255
    parameter int CNT_W       = 8    // 2**CNT_W > HOLD_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    d_sel_arb_if.slave  arb
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] G_ONE = 2'd1;
    localparam logic [1:0] G_TWO = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             hold_done;
    logic             enter;
    logic             sel_q, grant_one_q, grant_two_q, busy_q;

`ifdef D_SEL_ARB_RR_EN
    // 1 = channel one served last; reset value points at TWO so ONE wins
    // the first tie.
    logic             last_one;
`endif

    assign hold_done = (cnt == HOLD_LAST);
    // A grant state is being entered from IDLE or from the other grant.
    assign enter     = (state_nxt != state) && (state_nxt != IDLE);

    // Next-state selection: dwell first, then fairness/priority.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb.req_one && arb.req_two) begin
`ifdef D_SEL_ARB_RR_EN
                    state_nxt = last_one ? G_TWO : G_ONE;
`else
                    state_nxt = G_ONE;
`endif
                end else if (arb.req_one) begin
                    state_nxt = G_ONE;
                end else if (arb.req_two) begin
                    state_nxt = G_TWO;
                end
            end
            G_ONE: begin
                if (hold_done) begin
`ifdef D_SEL_ARB_RR_EN
                    if (arb.req_two)       state_nxt = G_TWO;
                    else if (!arb.req_one) state_nxt = IDLE;
`else
                    // Channel one keeps the selector while it still asks.
                    if (!arb.req_one)      state_nxt = arb.req_two ? G_TWO : IDLE;
`endif
                end
            end
            G_TWO: begin
                if (hold_done) begin
                    if (arb.req_one)       state_nxt = G_ONE;
                    else if (!arb.req_two) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_q       <= 1'b0;
            grant_one_q <= 1'b0;
            grant_two_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            if (enter)
                cnt <= '0;
            else if (state != IDLE && !hold_done)
                cnt <= cnt + 1'b1;
            // sel only moves on grant entry so it holds through IDLE.
            if (enter)
                sel_q <= (state_nxt == G_ONE);
            grant_one_q <= (state_nxt == G_ONE);
            grant_two_q <= (state_nxt == G_TWO);
            busy_q      <= (state_nxt != IDLE);
        end
    end

`ifdef D_SEL_ARB_RR_EN
    // Last-served pointer follows every grant entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_one <= 1'b0;
        else if (enter)
            last_one <= (state_nxt == G_ONE);
    end
`endif

    assign arb.sel       = sel_q;
    assign arb.grant_one = grant_one_q;
    assign arb.grant_two = grant_two_q;
    assign arb.busy      = busy_q;
endmodule

// File: tb/tb_d_sel_arb.sv
// tb_d_sel_arb: two arbiters (HOLD_CYCLES 4 and 1) share one request
// stream; each is compared every cycle with a cycle-count reference model.
module tb_d_sel_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   r1, r2;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    d_sel_arb_if if4();
    d_sel_arb_if if1();
    assign if4.req_one = r1;
    assign if4.req_two = r2;
    assign if1.req_one = r1;
    assign if1.req_two = r2;

    d_sel_arb #(.HOLD_CYCLES(4), .CNT_W(8)) u_arb4 (.clk(clk), .rst_n(rst_n), .arb(if4.slave));
    d_sel_arb #(.HOLD_CYCLES(1), .CNT_W(2)) u_arb1 (.clk(clk), .rst_n(rst_n), .arb(if1.slave));

    // owner: 0 none, 1 channel one, 2 channel two; held: cycles granted so far
    typedef struct {
        int owner;
        int held;
        int last;
        bit sel;
    } mdl_t;

    mdl_t m4, m1;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.owner = 0; m.held = 0; m.last = 2; m.sel = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_enter(mdl_t m, int c);
        mdl_t n = m;
        n.owner = c; n.held = 1; n.last = c; n.sel = (c == 1);
        return n;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int hold, bit a, bit b);
        mdl_t n = m;
        bit want [3];
        want[0] = 1'b0; want[1] = a; want[2] = b;
        if (m.owner == 0) begin
            int w = 0;
            if (a && b) begin
`ifdef D_SEL_ARB_RR_EN
                w = (m.last == 1) ? 2 : 1;
`else
                w = 1;
`endif
            end else if (a) w = 1;
            else if (b) w = 2;
            if (w != 0) n = mdl_enter(m, w);
        end else if (m.held < hold) begin
            n.held = m.held + 1;
        end else begin
            int own = m.owner;
            int oth = 3 - m.owner;
            bit yield = want[oth];
`ifndef D_SEL_ARB_RR_EN
            if (own == 1) yield = b && !a;
`endif
            if (yield) n = mdl_enter(m, oth);
            else if (!want[own]) begin n.owner = 0; n.held = 0; end
            else n.held = m.held + 1;
        end
        return n;
    endfunction

    function automatic logic [3:0] mdl_out(mdl_t m);
        return {m.sel, m.owner == 1, m.owner == 2, m.owner != 0};
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t {sel,g1,g2,busy} got=%b exp=%b", tag, $time, got, exp);
        end
    endtask

    // One cycle: drive at negedge, model steps on posedge, compare #1 later.
    task automatic tick(input bit a, input bit b, input bit rn, input string tag);
        @(negedge clk);
        r1 = a; r2 = b; rst_n = rn;
        @(posedge clk);
        #1;
        if (rst_n) begin
            m4 = mdl_step(m4, 4, a, b);
            m1 = mdl_step(m1, 1, a, b);
        end
        chk({tag, "_h4"}, {if4.sel, if4.grant_one, if4.grant_two, if4.busy}, mdl_out(m4));
        chk({tag, "_h1"}, {if1.sel, if1.grant_one, if1.grant_two, if1.busy}, mdl_out(m1));
    endtask

    // Assert reset away from any clock edge; outputs must clear at once.
    task automatic async_rst(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m4 = mdl_reset();
        m1 = mdl_reset();
        chk({tag, "_h4"}, {if4.sel, if4.grant_one, if4.grant_two, if4.busy}, 4'b0000);
        chk({tag, "_h1"}, {if1.sel, if1.grant_one, if1.grant_two, if1.busy}, 4'b0000);
    endtask

    initial begin
        m4 = mdl_reset();
        m1 = mdl_reset();
        r1 = 1'b1; r2 = 1'b1;

        // reset held with both requests up, then first grant to ONE
        repeat (3) tick(1, 1, 0, "reset");
        tick(1, 1, 1, "first");
        repeat (6) tick(0, 0, 1, "drain");

        // single-cycle req_two pulse
        tick(0, 1, 1, "pulse2");
        repeat (7) tick(0, 0, 1, "pulse2_rel");

        // sustained contention, then drop req_one
        repeat (20) tick(1, 1, 1, "contend");
        repeat (6) tick(0, 1, 1, "drop1");
        repeat (2) tick(0, 0, 1, "idle");

        // reset two cycles into G_ONE, restart with only req_two
        repeat (2) tick(1, 0, 1, "pre_rst");
        async_rst("rst_mid");
        tick(0, 1, 0, "in_rst");
        tick(0, 1, 1, "after_rst");
        repeat (6) tick(0, 0, 1, "drain2");

        // alternating single-cycle requests
        for (int i = 0; i < 10; i++)
            tick(i % 2 == 0, i % 2 == 1, 1, "alt");
        repeat (6) tick(0, 0, 1, "drain3");

        // randomized sticky requests with occasional resets
        for (int i = 0; i < 3000; i++) begin
            bit a = r1;
            bit b = r2;
            if ($urandom_range(3) == 0) a = ~a;
            if ($urandom_range(3) == 0) b = ~b;
            if ($urandom_range(249) == 0) begin
                async_rst("rnd_rst");
                tick(a, b, 0, "rnd_in_rst");
            end else begin
                tick(a, b, 1, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
